// File: rtl/imem_arbiter.sv
// imem_arbiter: round-robin sharing of one 2-cycle-latency instruction memory read port between fetch (F) and load (D)
module imem_arbiter #(
  parameter int DEPTH  = 64,
  parameter int ADDR_W = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              f_valid,
  input  logic [ADDR_W-1:0] f_addr,
  output logic              f_ready,
  output logic              f_rvalid,
  output logic [31:0]       f_rdata,
  output logic              f_err,
  input  logic              d_valid,
  input  logic [ADDR_W-1:0] d_addr,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [31:0]       d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata
);
  localparam logic [ADDR_W-1:0] L_DEPTH = ADDR_W'(DEPTH);
  logic              r_prio, r_s1_v, r_s1_port, r_s1_err;
  logic [ADDR_W-1:0] r_mem_addr, w_addr;
  logic              w_gnt, w_err;
  always_comb begin
    f_ready  = !reset && f_valid && (!d_valid || !r_prio);
    d_ready  = !reset && d_valid && !f_ready;
    w_gnt    = f_ready || d_ready;
    w_addr   = f_ready ? f_addr : d_addr;
    w_err    = w_addr >= L_DEPTH;
    mem_en   = w_gnt && !w_err;
    mem_addr = w_gnt ? w_addr : r_mem_addr;
  end
  // The capture stage feeds the per-port response registers directly, so they double as stage 2.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_prio     <= 1'b0;
      r_mem_addr <= '0;
      r_s1_v     <= 1'b0;
      r_s1_port  <= 1'b0;
      r_s1_err   <= 1'b0;
      f_rvalid   <= 1'b0;
      d_rvalid   <= 1'b0;
      f_rdata    <= '0;
      d_rdata    <= '0;
      f_err      <= 1'b0;
      d_err      <= 1'b0;
    end else begin
      if (w_gnt) begin
        r_prio     <= f_ready;
        r_mem_addr <= w_addr;
      end
      r_s1_v    <= w_gnt;
      r_s1_port <= d_ready;
      r_s1_err  <= w_err;
      f_rvalid  <= r_s1_v && !r_s1_port;
      d_rvalid  <= r_s1_v && r_s1_port;
      if (r_s1_v && !r_s1_port) begin
        f_rdata <= r_s1_err ? '0 : mem_rdata;
        f_err   <= r_s1_err;
      end
      if (r_s1_v && r_s1_port) begin
        d_rdata <= r_s1_err ? '0 : mem_rdata;
        d_err   <= r_s1_err;
      end
    end
  end
endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: directed and random traffic checked against a queue-based response model
module tb_imem_arbiter;
  localparam int DEPTH  = 64;
  localparam int ADDR_W = 30;
  logic              clk = 1'b0, reset = 1'b1;
  logic              f_valid = 1'b0, d_valid = 1'b0;
  logic [ADDR_W-1:0] f_addr = '0, d_addr = '0;
  logic              f_ready, f_rvalid, f_err, d_ready, d_rvalid, d_err, mem_en;
  logic [31:0]       f_rdata, d_rdata;
  logic [31:0]       mem_rdata = '0;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem [DEPTH];
  imem_arbiter #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset),
    .f_valid(f_valid), .f_addr(f_addr), .f_ready(f_ready),
    .f_rvalid(f_rvalid), .f_rdata(f_rdata), .f_err(f_err),
    .d_valid(d_valid), .d_addr(d_addr), .d_ready(d_ready),
    .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_rdata(mem_rdata)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_en) mem_rdata <= mem[mem_addr[5:0]];
  typedef struct {
    int          due;
    logic        port;
    logic        err;
    logic [31:0] data;
  } resp_t;
  resp_t       q[$];
  int          cyc = 0, n_chk = 0, n_fail = 0;
  logic        prio = 1'b0, g_f = 1'b0, g_d = 1'b0;
  logic [31:0] f_rd = '0, d_rd = '0;
  logic        f_er = 1'b0, d_er = 1'b0;
  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", tag, cyc, act, exp);
    end
  endtask
  task automatic cycle();
    resp_t             r;
    logic              dl_f, dl_d, err;
    logic [ADDR_W-1:0] a;
    @(negedge clk);
    dl_f = 1'b0;
    dl_d = 1'b0;
    if (q.size() > 0 && q[0].due == cyc) begin
      r = q.pop_front();
      if (r.port) begin dl_d = 1'b1; d_rd = r.data; d_er = r.err; end
      else begin dl_f = 1'b1; f_rd = r.data; f_er = r.err; end
    end
    check("f_rvalid", f_rvalid, dl_f);
    check("f_rdata", f_rdata, f_rd);
    check("f_err", f_err, f_er);
    check("d_rvalid", d_rvalid, dl_d);
    check("d_rdata", d_rdata, d_rd);
    check("d_err", d_err, d_er);
    g_f = !reset && f_valid && (!d_valid || !prio);
    g_d = !reset && d_valid && !g_f;
    a   = g_f ? f_addr : d_addr;
    err = a >= DEPTH;
    check("f_ready", f_ready, g_f);
    check("d_ready", d_ready, g_d);
    check("mem_en", mem_en, (g_f || g_d) && !err);
    if ((g_f || g_d) && !err) check("mem_addr", mem_addr, a);
    if (g_f || g_d) begin
      q.push_back('{cyc + 2, g_d, err, err ? 32'h0 : mem[a[5:0]]});
      prio = g_f;
    end
    if (reset) begin
      q.delete();
      prio = 1'b0;
      f_rd = '0; d_rd = '0; f_er = 1'b0; d_er = 1'b0;
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask
  initial begin
    foreach (mem[i]) mem[i] = $urandom;
    mem[5] = 32'hDEADBEEF;
    repeat (3) cycle();
    reset = 1'b0;
    f_valid = 1'b1; f_addr = 5; cycle();
    f_valid = 1'b0; repeat (11) cycle();
    f_valid = 1'b1; f_addr = 64; cycle();
    f_addr = 3; cycle();
    f_valid = 1'b0; repeat (3) cycle();
    d_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin d_addr = ADDR_W'(i); cycle(); end
    d_valid = 1'b0; repeat (3) cycle();
    reset = 1'b1; cycle();
    reset = 1'b0; f_valid = 1'b1; d_valid = 1'b1; f_addr = 1; d_addr = 2;
    repeat (8) cycle();
    f_valid = 1'b0; d_valid = 1'b0; repeat (3) cycle();
    f_valid = 1'b1; d_valid = 1'b1; cycle();
    f_valid = 1'b0; d_valid = 1'b0; repeat (5) cycle();
    f_valid = 1'b1; d_valid = 1'b1; cycle();
    f_valid = 1'b0; d_valid = 1'b0; repeat (3) cycle();
    d_valid = 1'b1; d_addr = 7; cycle();
    d_valid = 1'b0; reset = 1'b1; cycle();
    reset = 1'b0; repeat (3) cycle();
    f_valid = 1'b1; d_valid = 1'b1; cycle();
    f_valid = 1'b0; d_valid = 1'b0; repeat (3) cycle();
    repeat (3000) begin
      reset = $urandom_range(0, 199) == 0;
      if (!f_valid || g_f) begin
        f_valid = $urandom_range(0, 2) != 0;
        f_addr  = ADDR_W'($urandom_range(0, 71));
      end
      if (!d_valid || g_d) begin
        d_valid = $urandom_range(0, 2) != 0;
        d_addr  = ADDR_W'($urandom_range(0, 71));
      end
      cycle();
    end
    reset = 1'b0; f_valid = 1'b0; d_valid = 1'b0;
    repeat (4) cycle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
